eject_arbiter: RTL and testbench

EJECT_ARBITER -- requirements
Module: eject_arbiter

---
 rtl/eject_pkg.sv | 51 +++++
 rtl/eject_fifo.sv | 59 +++++
 rtl/eject_arbiter.sv | 122 ++++++++++++
 tb/tb_eject_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eject_pkg.sv
// +----------------------------------------------------------------------------+
// | eject_pkg : shared flit constants, types and helpers for eject_arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package eject_pkg;

    localparam int FLIT_W    = 11;
    localparam int VALID_BIT = 10;
    localparam int DEST_MSB  = 5;
    localparam int DEST_LSB  = 0;
    localparam int NUM_PORTS = 4;

    localparam logic [1:0] PORT_N = 2'd0;
    localparam logic [1:0] PORT_S = 2'd1;
    localparam logic [1:0] PORT_E = 2'd2;
    localparam logic [1:0] PORT_W = 2'd3;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } grant_t;

    // First requester at or after ptr, wrapping; descending scan lets the
    // nearest port overwrite farther ones.
    function automatic grant_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        grant_t     g;
        logic [1:0] p;
        g = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            p = ptr + 2'(k);
            if (req[p]) begin
                g.found = 1'b1;
                g.idx   = p;
            end
        end
        return g;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/eject_fifo.sv
// +----------------------------------------------------------------------------+
// | eject_fifo : synchronous in-order flit FIFO feeding the local port         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module eject_fifo
    import eject_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  flit_t din,
    output flit_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    flit_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/eject_arbiter.sv
// +----------------------------------------------------------------------------+
// | eject_arbiter : round-robin ejection of local flits into a FIFO, with      |
// | registered pass-through. Optional counters: define EJECT_STATS_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module eject_arbiter
    import eject_pkg::*;
#(
    parameter logic [5:0] LOCAL_ADDR = 6'b100100,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] northad,
    input  logic [FLIT_W-1:0] southad,
    input  logic [FLIT_W-1:0] eastad,
    input  logic [FLIT_W-1:0] westad,
    output logic [FLIT_W-1:0] nad,
    output logic [FLIT_W-1:0] sad,
    output logic [FLIT_W-1:0] ead,
    output logic [FLIT_W-1:0] wad,
    output logic [FLIT_W-1:0] lad,
    output logic              lad_valid,
    input  logic              lad_ready,
    output logic [15:0]       ej_cnt,
    output logic [15:0]       defl_cnt
);

    flit_t        w_in [NUM_PORTS];
    logic [3:0]   w_valid;
    logic [3:0]   w_local;
    logic [3:0]   w_req;
    grant_t       w_gnt;
    logic         w_pop;
    logic         w_can_accept;
    logic         w_full;
    logic         w_empty;
    flit_t        r_out [NUM_PORTS];
    logic [1:0]   r_rr_ptr;

    assign w_in[PORT_N] = northad;
    assign w_in[PORT_S] = southad;
    assign w_in[PORT_E] = eastad;
    assign w_in[PORT_W] = westad;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign w_valid[i] = (w_in[i][VALID_BIT] == 1'b1);
        assign w_local[i] = w_valid[i] && (w_in[i][DEST_MSB:DEST_LSB] == LOCAL_ADDR);
    end

    // A pop frees the slot the push lands in, so a full FIFO may still accept.
    assign w_pop        = lad_valid & lad_ready;
    assign w_can_accept = ~w_full | w_pop;
    assign w_req        = w_can_accept ? w_local : 4'b0000;
    assign w_gnt        = rr_pick(w_req, r_rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) r_out[i] <= '0;
            r_rr_ptr <= PORT_N;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_valid[i] && !(w_gnt.found && (w_gnt.idx == 2'(i))))
                    r_out[i] <= w_in[i];
                else
                    r_out[i] <= '0;
            end
            if (w_gnt.found) r_rr_ptr <= w_gnt.idx + 2'd1;
        end
    end

    eject_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_gnt.found),
        .pop   (w_pop),
        .din   (w_in[w_gnt.idx]),
        .dout  (lad),
        .full  (w_full),
        .empty (w_empty)
    );

    assign lad_valid = ~w_empty;
    assign nad       = r_out[PORT_N];
    assign sad       = r_out[PORT_S];
    assign ead       = r_out[PORT_E];
    assign wad       = r_out[PORT_W];

`ifdef EJECT_STATS_EN
    logic [2:0]  w_loc_cnt;
    logic [2:0]  w_defl_inc;
    logic [15:0] r_ej_cnt;
    logic [15:0] r_defl_cnt;

    assign w_loc_cnt  = {2'b0, w_local[0]} + {2'b0, w_local[1]}
                      + {2'b0, w_local[2]} + {2'b0, w_local[3]};
    assign w_defl_inc = w_loc_cnt - {2'b0, w_gnt.found};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ej_cnt   <= '0;
            r_defl_cnt <= '0;
        end else begin
            r_ej_cnt   <= sat_add16(r_ej_cnt, {2'b0, w_gnt.found});
            r_defl_cnt <= sat_add16(r_defl_cnt, w_defl_inc);
        end
    end

    assign ej_cnt   = r_ej_cnt;
    assign defl_cnt = r_defl_cnt;
`else
    assign ej_cnt   = 16'h0000;
    assign defl_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eject_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_eject_arbiter : directed and random checks of eject_arbiter against a   |
// | queue-based reference model. Rev 1.0                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_eject_arbiter;

    localparam logic [5:0] LA    = 6'b100100;
    localparam int         DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] northad, southad, eastad, westad;
    logic [10:0] nad, sad, ead, wad, lad;
    logic        lad_valid;
    logic        lad_ready;
    logic [15:0] ej_cnt, defl_cnt;

    int tests = 0;
    int fails = 0;

    logic [10:0] q[$];
    logic [10:0] exp_out [4];
    int          m_rr;
    int          m_ej;
    int          m_defl;

    eject_arbiter #(
        .LOCAL_ADDR (LA),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .northad   (northad),
        .southad   (southad),
        .eastad    (eastad),
        .westad    (westad),
        .nad       (nad),
        .sad       (sad),
        .ead       (ead),
        .wad       (wad),
        .lad       (lad),
        .lad_valid (lad_valid),
        .lad_ready (lad_ready),
        .ej_cnt    (ej_cnt),
        .defl_cnt  (defl_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic [3:0] payload);
        return {1'b1, payload, LA};
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 4; i++) exp_out[i] = '0;
        m_rr   = 0;
        m_ej   = 0;
        m_defl = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_nad"}, {5'b0, nad}, 16'h0);
        chk({tag, "_sad"}, {5'b0, sad}, 16'h0);
        chk({tag, "_ead"}, {5'b0, ead}, 16'h0);
        chk({tag, "_wad"}, {5'b0, wad}, 16'h0);
        chk({tag, "_lad"}, {5'b0, lad}, 16'h0);
        chk({tag, "_lad_valid"}, {15'b0, lad_valid}, 16'h0);
        chk({tag, "_ej_cnt"}, ej_cnt, 16'h0);
        chk({tag, "_defl_cnt"}, defl_cnt, 16'h0);
    endtask

    task automatic check_all(input string tag);
        logic [10:0] head;
        head = (q.size() > 0) ? q[0] : 11'b0;
        chk({tag, "_nad"}, {5'b0, nad}, {5'b0, exp_out[0]});
        chk({tag, "_sad"}, {5'b0, sad}, {5'b0, exp_out[1]});
        chk({tag, "_ead"}, {5'b0, ead}, {5'b0, exp_out[2]});
        chk({tag, "_wad"}, {5'b0, wad}, {5'b0, exp_out[3]});
        chk({tag, "_lad"}, {5'b0, lad}, {5'b0, head});
        chk({tag, "_lad_valid"}, {15'b0, lad_valid}, {15'b0, (q.size() > 0)});
`ifdef EJECT_STATS_EN
        chk({tag, "_ej_cnt"}, ej_cnt, 16'(m_ej));
        chk({tag, "_defl_cnt"}, defl_cnt, 16'(m_defl));
`else
        chk({tag, "_ej_cnt"}, ej_cnt, 16'h0);
        chk({tag, "_defl_cnt"}, defl_cnt, 16'h0);
`endif
    endtask

    // One clock of stimulus; the model decides the grant from the rules,
    // then outputs are checked 1 time unit after the edge.
    task automatic step(input string tag, input logic [10:0] n, input logic [10:0] s,
                        input logic [10:0] e, input logic [10:0] w, input logic rdy);
        logic [10:0] f [4];
        bit          loc [4];
        int          g, nloc, p;
        bit          pop, can;
        northad = n; southad = s; eastad = e; westad = w; lad_ready = rdy;
        f[0] = n; f[1] = s; f[2] = e; f[3] = w;
        pop  = (q.size() > 0) && rdy;
        can  = (q.size() < DEPTH) || pop;
        nloc = 0;
        for (int k = 0; k < 4; k++) begin
            loc[k] = (f[k][10] === 1'b1) && (f[k][5:0] == LA);
            if (loc[k]) nloc++;
        end
        g = -1;
        if (can) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if (g < 0 && loc[p]) g = p;
            end
        end
        for (int i = 0; i < 4; i++)
            exp_out[i] = ((f[i][10] === 1'b1) && (i != g)) ? f[i] : 11'b0;
        if (pop) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(f[g]);
            m_rr = (g + 1) % 4;
            m_ej = sat(m_ej + 1);
        end
        m_defl = sat(m_defl + nloc - ((g >= 0) ? 1 : 0));
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [10:0] rnd_flit();
        logic [10:0] f;
        f[10]  = ($urandom % 4) != 0;
        f[9:6] = 4'($urandom);
        f[5:0] = (($urandom % 2) != 0) ? LA : 6'($urandom);
        return f;
    endfunction

    initial begin
        rst_n = 1'b0;
        northad = '0; southad = '0; eastad = '0; westad = '0;
        lad_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        // Single local flit on N; held in FIFO.
        step("n_local", 11'b10000100100, 11'b0, 11'b0, 11'b0, 1'b0);

        // All local, pointer at S: grants S, E, W, N.
        for (int c = 0; c < 4; c++)
            step("rr_all", mk(4'(4 * c + 0)), mk(4'(4 * c + 1)), mk(4'(4 * c + 2)), mk(4'(4 * c + 3)), 1'b1);
        step("drain", 11'b0, 11'b0, 11'b0, 11'b0, 1'b1);
        step("drain", 11'b0, 11'b0, 11'b0, 11'b0, 1'b1);

        // Fill to depth on E with no pop; third flit is deflected.
        do_reset();
        step("fill_e", 11'b0, 11'b0, mk(4'h1), 11'b0, 1'b0);
        step("fill_e", 11'b0, 11'b0, mk(4'h2), 11'b0, 1'b0);
        step("fill_e", 11'b0, 11'b0, mk(4'h3), 11'b0, 1'b0);
        chk("defl_e_ead", {5'b0, ead}, {5'b0, mk(4'h3)});
`ifdef EJECT_STATS_EN
        chk("defl_e_ej2", ej_cnt, 16'd2);
        chk("defl_e_defl1", defl_cnt, 16'd1);
`endif

        // Full FIFO, pop and push together on W.
        step("full_w", 11'b0, 11'b0, 11'b0, mk(4'h9), 1'b1);
        step("full_drain", 11'b0, 11'b0, 11'b0, 11'b0, 1'b1);
        step("full_drain", 11'b0, 11'b0, 11'b0, 11'b0, 1'b1);

        // Empty FIFO, push and pop in the same cycle.
        step("push_one", mk(4'h4), 11'b0, 11'b0, 11'b0, 1'b0);
        step("push_pop", 11'b0, mk(4'h5), 11'b0, 11'b0, 1'b1);

        // No valid bits; plus a valid non-local flit.
        step("invalid", 11'b0, 11'b00000111111, 11'b00001100100, 11'b0, 1'b0);
        step("nonlocal", 11'b10000000001, 11'b0, 11'b00000100100, 11'b11111111111, 1'b0);

        // Asynchronous reset mid-cycle with entries buffered.
        do_reset();
        step("pre_arst", mk(4'h6), 11'b0, 11'b0, mk(4'h7), 1'b0);
        step("pre_arst", mk(4'h8), 11'b0, 11'b0, 11'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_arst", mk(4'hA), mk(4'hB), mk(4'hC), mk(4'hD), 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++)
            step("rand", rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit(), ($urandom % 3) != 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
